// File: rtl/seq_alu_exec.sv
// Sequential ALU execute stage: single-cycle ops finish in one cycle, shifts
// iterate one bit per cycle in a working register that doubles as the result.
module seq_alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] res_q, res_nx;
  logic [SHW-1:0]   cnt_q, cnt_nx;
  logic [3:0]       op_q, op_nx;
  logic             ill_q, ill_nx;

  logic [WIDTH-1:0] alu_val;
  logic             is_ill, is_shift;
  logic [SHW-1:0]   shamt;

  assign shamt    = src_b[SHW-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  // Shift codes yield src_a here: that is the shift-by-0 answer and the
  // starting value for the iterative path.
  always_comb begin
    alu_val = '0;
    is_ill  = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_val = src_a + src_b;
      OP_SUB:  alu_val = src_a - src_b;
      OP_AND:  alu_val = src_a & src_b;
      OP_OR:   alu_val = src_a | src_b;
      OP_XOR:  alu_val = src_a ^ src_b;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLL, OP_SRL, OP_SRA: alu_val = src_a;
      default: is_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    res_nx   = res_q;
    cnt_nx   = cnt_q;
    op_nx    = op_q;
    ill_nx   = ill_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_nx  = alu_ctrl;
          ill_nx = is_ill;
          res_nx = alu_val;
          if (is_shift && shamt != '0) begin
            cnt_nx   = shamt;
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SHIFT: begin
        // sra replicates the MSB each step, so the original sign persists
        case (op_q)
          OP_SLL:  res_nx = {res_q[WIDTH-2:0], 1'b0};
          OP_SRL:  res_nx = {1'b0, res_q[WIDTH-1:1]};
          default: res_nx = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        endcase
        cnt_nx = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      res_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      res_q <= res_nx;
      cnt_q <= cnt_nx;
      op_q  <= op_nx;
      ill_q <= ill_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign zero      = (res_q == '0);
  assign illegal   = ill_q;

endmodule

// File: tb/tb_seq_alu_exec.sv
// Directed plus randomized bench for seq_alu_exec against a plain-arithmetic
// reference model of each operation and its expected latency.
module tb_seq_alu_exec;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int cmp_cnt = 0;
  int err_cnt = 0;

  seq_alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output int lat);
    int n;
    n = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << n;
      4'd8: r = a >> n;
      4'd9: r = $signed(a) >>> n;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    if (c == 4'd7 || c == 4'd8 || c == 4'd9) lat = n + 1;
  endtask

  // Issue one op, scramble inputs while it is in flight, stall the consumer,
  // then retire it and confirm the bubble cycle.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    model(c, a, b, er, ei, el);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_result"}, result, er);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_stall_result"}, result, er);
      chk({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_bubble_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_bubble_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    // reset state while held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
    do_op("sra31", 4'd9, 32'h8000_0000, 32'd31, 0);
    do_op("srl31", 4'd8, 32'h8000_0000, 32'd31, 0);
    do_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sll0", 4'd7, 32'd1, 32'd0, 0);
    do_op("illegal", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op("add_after_ill", 4'd0, 32'd3, 32'd4, 0);
    do_op("stall5", 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5);
    do_op("sll31", 4'd7, 32'h0000_0003, 32'hFFFF_FFFF, 0);

    // reset mid-shift
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'd7; src_a = $urandom | 32'd1; src_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_shift_valid", {31'd0, out_valid}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_zero", {31'd0, zero}, 32'd1);
    chk("async_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst_hold_result", result, 32'd0);
    chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_rst_add", 4'd0, 32'h0000_1000, 32'h0000_0234, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (k % 5 == 0) a = b;
      do_op($sformatf("rnd%0d", k), c, a, b, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
